// File: rtl/sched_pkg.sv
// Shared definitions for the crossbar controller and its scheduler.
// Holds the port geometry, the WAIT timeout and the controller state encoding.
package sched_pkg;
    localparam int N_PORTS      = 4;
    localparam int PORT_W       = 2;
    localparam int WAIT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        XFER = 2'd3
    } state_t;
endpackage

// File: rtl/xbar_ctrl_if.sv
// Scheduler handshake and crossbar drive bundle between xbar_ctrl (master)
// and the scheduler / crossbar fabric (slave).
interface xbar_ctrl_if;
    import sched_pkg::*;

    logic [N_PORTS*N_PORTS-1:0] voq_empty;
    logic [N_PORTS-1:0]         pkt_last;
    logic                       sched_sel_en;
    logic [N_PORTS*PORT_W-1:0]  sched_sel;
    logic                       sched_en;
    logic [N_PORTS-1:0]         is_busy;
    logic [N_PORTS*PORT_W-1:0]  busy_voq_num;
    logic [N_PORTS-1:0]         xbar_en;
    logic [N_PORTS*PORT_W-1:0]  xbar_sel;

    modport master (
        input  voq_empty, pkt_last, sched_sel_en, sched_sel,
        output sched_en, is_busy, busy_voq_num, xbar_en, xbar_sel
    );

    modport slave (
        output voq_empty, pkt_last, sched_sel_en, sched_sel,
        input  sched_en, is_busy, busy_voq_num, xbar_en, xbar_sel
    );
endinterface

// File: rtl/xbar_grant.sv
// Combinational egress arbitration: among candidates aiming at one egress, a busy
// ingress wins first, then the lowest index; any losing candidate flags a conflict.
module xbar_grant
    import sched_pkg::*;
(
    input  logic [N_PORTS-1:0]        cand,
    input  logic [N_PORTS-1:0]        busy,
    input  logic [N_PORTS*PORT_W-1:0] sel,
    output logic [N_PORTS-1:0]        grant,
    output logic                      conflict
);
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            logic lose;

            // Ingress gi loses if any other candidate on the same egress outranks it.
            always_comb begin
                lose = 1'b0;
                for (int j = 0; j < N_PORTS; j++) begin
                    if (j != gi && cand[j] &&
                        sel[j*PORT_W +: PORT_W] == sel[gi*PORT_W +: PORT_W]) begin
                        if ((busy[j] && !busy[gi]) || (busy[j] == busy[gi] && j < gi)) begin
                            lose = 1'b1;
                        end
                    end
                end
            end

            assign grant[gi] = cand[gi] & ~lose;
        end
    endgenerate

    assign conflict = |(cand & ~grant);
endmodule

// File: rtl/xbar_ctrl.sv
// Crossbar slot controller: requests a schedule, arbitrates the answer, holds the
// crossbar for one slot and tracks which ingresses are mid-packet.
module xbar_ctrl #(
    parameter int N_PORTS      = sched_pkg::N_PORTS,
    parameter int WAIT_TIMEOUT = sched_pkg::WAIT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  slot_len,
    xbar_ctrl_if.master bus,
    output logic [15:0] slot_cnt,
    output logic        err_timeout,
    output logic        err_conflict
);
    localparam int         PW        = sched_pkg::PORT_W;
    localparam int         SW        = N_PORTS * PW;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

    sched_pkg::state_t state_reg, state_next;

    logic [7:0]         wait_cnt_reg, wait_cnt_next;
    logic [7:0]         xfer_cnt_reg, xfer_cnt_next;
    logic [7:0]         len_reg, len_next;
    logic [N_PORTS-1:0] acc_reg, acc_next;
    logic [N_PORTS-1:0] busy_reg, busy_next;
    logic [SW-1:0]      vnum_reg, vnum_next;
    logic [N_PORTS-1:0] en_reg, en_next;
    logic [SW-1:0]      sel_reg, sel_next;
    logic [15:0]        slot_cnt_reg, slot_cnt_next;
    logic               err_to_reg, err_to_next;
    logic               err_cf_reg, err_cf_next;

    logic [N_PORTS-1:0] acc_sum;
    logic [SW-1:0]      eff_sel;
    logic [N_PORTS-1:0] cand;
    logic [N_PORTS-1:0] grant;
    logic               conflict;

    // Busy ingresses keep their egress; others take the scheduler's pick.
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cand
            assign eff_sel[gi*PW +: PW] = busy_reg[gi] ? vnum_reg[gi*PW +: PW]
                                                       : bus.sched_sel[gi*PW +: PW];
            assign cand[gi] = busy_reg[gi] |
                              ~bus.voq_empty[gi*N_PORTS + 32'(eff_sel[gi*PW +: PW])];
        end
    endgenerate

    xbar_grant u_grant (
        .cand     (cand),
        .busy     (busy_reg),
        .sel      (eff_sel),
        .grant    (grant),
        .conflict (conflict)
    );

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        xfer_cnt_next = xfer_cnt_reg;
        len_next      = len_reg;
        acc_next      = acc_reg;
        busy_next     = busy_reg;
        vnum_next     = vnum_reg;
        en_next       = en_reg;
        sel_next      = sel_reg;
        slot_cnt_next = slot_cnt_reg;
        err_to_next   = err_to_reg;
        err_cf_next   = err_cf_reg;
        acc_sum       = acc_reg | bus.pkt_last;

        case (state_reg)
            sched_pkg::IDLE: begin
                if (enable) state_next = sched_pkg::REQ;
            end
            sched_pkg::REQ: begin
                wait_cnt_next = 8'd0;
                state_next    = sched_pkg::WAIT;
            end
            sched_pkg::WAIT: begin
                if (bus.sched_sel_en) begin
                    en_next       = grant;
                    sel_next      = eff_sel;
                    len_next      = (slot_len == 8'd0) ? 8'd1 : slot_len;
                    xfer_cnt_next = 8'd0;
                    acc_next      = '0;
                    if (conflict) err_cf_next = 1'b1;
                    state_next    = sched_pkg::XFER;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    err_to_next = 1'b1;
                    state_next  = sched_pkg::REQ;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            sched_pkg::XFER: begin
                if (xfer_cnt_reg == len_reg - 8'd1) begin
                    // Slot end: settle packet ownership for every driving ingress.
                    for (int i = 0; i < N_PORTS; i++) begin
                        if (en_reg[i]) begin
                            busy_next[i] = ~acc_sum[i];
                            if (!acc_sum[i]) vnum_next[i*PW +: PW] = sel_reg[i*PW +: PW];
                        end
                    end
                    acc_next      = '0;
                    en_next       = '0;
                    sel_next      = '0;
                    slot_cnt_next = slot_cnt_reg + 16'd1;
                    state_next    = enable ? sched_pkg::REQ : sched_pkg::IDLE;
                end else begin
                    acc_next      = acc_sum;
                    xfer_cnt_next = xfer_cnt_reg + 8'd1;
                end
            end
            default: state_next = sched_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= sched_pkg::IDLE;
            wait_cnt_reg <= '0;
            xfer_cnt_reg <= '0;
            len_reg      <= '0;
            acc_reg      <= '0;
            busy_reg     <= '0;
            vnum_reg     <= '0;
            en_reg       <= '0;
            sel_reg      <= '0;
            slot_cnt_reg <= '0;
            err_to_reg   <= 1'b0;
            err_cf_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            xfer_cnt_reg <= xfer_cnt_next;
            len_reg      <= len_next;
            acc_reg      <= acc_next;
            busy_reg     <= busy_next;
            vnum_reg     <= vnum_next;
            en_reg       <= en_next;
            sel_reg      <= sel_next;
            slot_cnt_reg <= slot_cnt_next;
            err_to_reg   <= err_to_next;
            err_cf_reg   <= err_cf_next;
        end
    end

    assign bus.sched_en     = (state_reg == sched_pkg::REQ);
    assign bus.is_busy      = busy_reg;
    assign bus.busy_voq_num = vnum_reg;
    assign bus.xbar_en      = en_reg;
    assign bus.xbar_sel     = sel_reg;
    assign slot_cnt         = slot_cnt_reg;
    assign err_timeout      = err_to_reg;
    assign err_conflict     = err_cf_reg;
endmodule

// File: tb/tb_xbar_ctrl.sv
// Directed plus randomized bench for xbar_ctrl against a slot-level reference model
// (per-egress winner search, packet ownership table, slot counter, sticky errors).
module tb_xbar_ctrl;
    localparam int T_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  slot_len;
    logic [15:0] slot_cnt;
    logic        err_timeout;
    logic        err_conflict;

    xbar_ctrl_if bus ();

    xbar_ctrl #(.N_PORTS(4), .WAIT_TIMEOUT(T_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .slot_len     (slot_len),
        .bus          (bus),
        .slot_cnt     (slot_cnt),
        .err_timeout  (err_timeout),
        .err_conflict (err_conflict)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_slots  = 0;

    logic [3:0]  m_busy;
    logic [1:0]  m_vnum [4];
    logic [15:0] m_cnt;
    logic        m_err_to;
    logic        m_err_cf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_busy   = '0;
        for (int i = 0; i < 4; i++) m_vnum[i] = '0;
        m_cnt    = '0;
        m_err_to = 1'b0;
        m_err_cf = 1'b0;
    endtask

    // For every egress, pick the winner among the ingresses aiming at it.
    task automatic model_grant(input logic [7:0] sel, input logic [15:0] ve,
                               output logic [3:0] en, output logic [7:0] esel, output bit cf);
        int tgt [4];
        bit can [4];
        en = '0; esel = '0; cf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tgt[i] = m_busy[i] ? int'(m_vnum[i]) : int'(sel[2*i +: 2]);
            can[i] = m_busy[i] || !ve[4*i + tgt[i]];
            esel[2*i +: 2] = 2'(tgt[i]);
        end
        for (int e = 0; e < 4; e++) begin
            int winner = -1;
            int count  = 0;
            for (int i = 0; i < 4; i++)
                if (can[i] && tgt[i] == e) begin
                    count++;
                    if (m_busy[i] && winner < 0) winner = i;
                end
            for (int i = 0; i < 4; i++)
                if (can[i] && tgt[i] == e && winner < 0) winner = i;
            if (winner >= 0) en[winner] = 1'b1;
            if (count > 1) cf = 1'b1;
        end
    endtask

    task automatic wait_sched_en(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (bus.sched_en === 1'b1) ok = 1'b1;
            else tick();
        end
        if (!ok) check("sched_en_wait", 32'(bus.sched_en), 32'd1);
    endtask

    task automatic run_slot(input logic [7:0] sel, input logic [15:0] ve, input int delay,
                            input logic [7:0] len, input bit drop_en, input bit use_fixed,
                            input logic [3:0] fixed_last, input bit stray,
                            output logic [3:0] first_en, output logic [7:0] first_sel);
        bit ok, cf;
        int n;
        logic [3:0] exp_en, acc, pl;
        logic [7:0] exp_sel, lane_mask, exp_vnum, obs_vnum;
        first_en = '0; first_sel = '0;
        wait_sched_en(ok);
        if (!ok) return;
        check("busy_in_req", 32'(bus.is_busy), 32'(m_busy));
        if (stray) begin
            bus.sched_sel_en = 1'b1;
            bus.sched_sel    = ~sel;
        end
        tick();
        bus.sched_sel_en = 1'b0;
        check("sched_en_pulse", 32'(bus.sched_en), 32'd0);
        for (int d = 0; d < delay; d++) begin
            check("xbar_en_wait", 32'(bus.xbar_en), 32'd0);
            tick();
        end
        bus.sched_sel_en = 1'b1;
        bus.sched_sel    = sel;
        bus.voq_empty    = ve;
        slot_len         = len;
        model_grant(sel, ve, exp_en, exp_sel, cf);
        n = (len == 8'd0) ? 1 : int'(len);
        tick();
        bus.sched_sel_en = 1'b0;
        slot_len = 8'($urandom_range(0, 255));
        if (drop_en) enable = 1'b0;
        lane_mask = '0;
        for (int i = 0; i < 4; i++) lane_mask[2*i +: 2] = {2{exp_en[i]}};
        acc = '0;
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                first_en  = bus.xbar_en;
                first_sel = bus.xbar_sel;
            end
            check("xbar_en", 32'(bus.xbar_en), 32'(exp_en));
            check("xbar_sel", 32'(bus.xbar_sel & lane_mask), 32'(exp_sel & lane_mask));
            check("busy_xfer", 32'(bus.is_busy), 32'(m_busy));
            pl = use_fixed ? fixed_last : 4'($urandom_range(0, 15));
            bus.pkt_last = pl;
            acc |= pl;
            tick();
        end
        bus.pkt_last = '0;
        for (int i = 0; i < 4; i++)
            if (exp_en[i]) begin
                m_busy[i] = !acc[i];
                if (!acc[i]) m_vnum[i] = exp_sel[2*i +: 2];
            end
        m_cnt++;
        if (cf) m_err_cf = 1'b1;
        exp_vnum = '0; obs_vnum = '0;
        for (int i = 0; i < 4; i++)
            if (m_busy[i]) begin
                exp_vnum[2*i +: 2] = m_vnum[i];
                obs_vnum[2*i +: 2] = bus.busy_voq_num[2*i +: 2];
            end
        check("xbar_en_after", 32'(bus.xbar_en), 32'd0);
        check("is_busy", 32'(bus.is_busy), 32'(m_busy));
        check("busy_voq_num", 32'(obs_vnum), 32'(exp_vnum));
        check("slot_cnt", 32'(slot_cnt), 32'(m_cnt));
        check("err_conflict", 32'(err_conflict), 32'(m_err_cf));
        check("err_timeout", 32'(err_timeout), 32'(m_err_to));
        n_slots++;
        $display("slot %0d: sel=%h voq_empty=%h len=%0d xbar_en=%h busy=%h slot_cnt=%h",
                 n_slots, sel, ve, n, exp_en, m_busy, m_cnt);
        if (drop_en) begin
            check("idle_no_req0", 32'(bus.sched_en), 32'd0);
            tick();
            check("idle_no_req1", 32'(bus.sched_en), 32'd0);
            enable = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  fen, exp_en;
        logic [7:0]  fsel, exp_sel, rsel;
        logic [15:0] ve;
        bit ok, cf, saw_xbar;
        int count;

        rst_n = 1'b0; enable = 1'b0; slot_len = 8'd0;
        bus.voq_empty = '0; bus.pkt_last = '0; bus.sched_sel_en = 1'b0; bus.sched_sel = '0;
        model_reset();
        tick(); tick();
        check("rst_sched_en", 32'(bus.sched_en), 32'd0);
        check("rst_is_busy", 32'(bus.is_busy), 32'd0);
        check("rst_busy_voq_num", 32'(bus.busy_voq_num), 32'd0);
        check("rst_xbar_en", 32'(bus.xbar_en), 32'd0);
        check("rst_xbar_sel", 32'(bus.xbar_sel), 32'd0);
        check("rst_slot_cnt", 32'(slot_cnt), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_err_conflict", 32'(err_conflict), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", 32'(bus.sched_en), 32'd0);
        enable = 1'b1;

        // Basic slot: full permutation, every packet ends.
        run_slot(8'hE4, 16'h0000, 1, 8'd4, 1'b0, 1'b1, 4'hF, 1'b0, fen, fsel);
        check("basic_xbar_en", 32'(fen), 32'hF);
        check("basic_xbar_sel", 32'(fsel), 32'hE4);
        check("basic_busy", 32'(bus.is_busy), 32'h0);
        check("basic_slot_cnt", 32'(slot_cnt), 32'd1);

        // Multi-slot packet on ingress 1 -> egress 2, then busy override.
        run_slot(8'hD8, 16'h0000, 0, 8'd2, 1'b0, 1'b1, 4'b1101, 1'b1, fen, fsel);
        check("multi_busy", 32'(bus.is_busy), 32'h2);
        check("multi_vnum1", 32'(bus.busy_voq_num[3:2]), 32'd2);
        run_slot(8'hD0, 16'h0000, 2, 8'd3, 1'b0, 1'b1, 4'hF, 1'b0, fen, fsel);
        check("override_sel1", 32'(fsel[3:2]), 32'd2);
        check("override_en1", 32'(fen[1]), 32'd1);

        // All ingresses onto egress 0: lowest index wins.
        run_slot(8'h00, 16'h0000, 0, 8'd2, 1'b0, 1'b1, 4'hF, 1'b0, fen, fsel);
        check("conflict_en", 32'(fen), 32'h1);
        check("conflict_flag", 32'(err_conflict), 32'd1);

        // Timeout: never answer.
        wait_sched_en(ok);
        tick();
        count = 1; saw_xbar = 1'b0;
        while (bus.sched_en !== 1'b1 && count < 40) begin
            if (bus.xbar_en !== 4'h0) saw_xbar = 1'b1;
            tick();
            count++;
        end
        m_err_to = 1'b1;
        check("timeout_req_gap", 32'(count), 32'(T_WAIT + 1));
        check("timeout_no_xbar", 32'(saw_xbar), 32'd0);
        check("timeout_flag", 32'(err_timeout), 32'd1);
        check("timeout_slot_cnt", 32'(slot_cnt), 32'(m_cnt));
        $display("timeout: sched_en re-issued after %0d cycles", count);

        // slot_len of zero behaves as one cycle.
        run_slot(8'h1B, 16'h0000, 0, 8'd0, 1'b0, 1'b0, 4'h0, 1'b0, fen, fsel);

        for (int s = 0; s < 40; s++) begin
            ve = '0;
            for (int b = 0; b < 16; b++) ve[b] = ($urandom_range(0, 9) < 3);
            rsel = 8'($urandom_range(0, 255));
            run_slot(rsel, ve, int'($urandom_range(0, 4)), 8'($urandom_range(0, 5)),
                     ($urandom_range(0, 7) == 0), 1'b0, 4'h0, ($urandom_range(0, 3) == 0),
                     fen, fsel);
        end

        // Enable dropped mid-slot, then counter wrap from a preset value.
        run_slot(8'hE4, 16'h0000, 1, 8'd3, 1'b1, 1'b0, 4'h0, 1'b0, fen, fsel);
        force dut.slot_cnt_reg = 16'hFFFE;
        #1;
        release dut.slot_cnt_reg;
        m_cnt = 16'hFFFE;
        run_slot(8'hE4, 16'h0000, 0, 8'd1, 1'b0, 1'b1, 4'hF, 1'b0, fen, fsel);
        run_slot(8'hE4, 16'h0000, 0, 8'd2, 1'b0, 1'b1, 4'hF, 1'b0, fen, fsel);
        check("wrap_slot_cnt", 32'(slot_cnt), 32'd0);

        // Reset in the middle of a transfer slot.
        wait_sched_en(ok);
        tick();
        bus.sched_sel_en = 1'b1; bus.sched_sel = 8'hE4; bus.voq_empty = '0; slot_len = 8'd6;
        model_grant(8'hE4, 16'h0000, exp_en, exp_sel, cf);
        tick();
        bus.sched_sel_en = 1'b0;
        check("pre_rst_xbar_en", 32'(bus.xbar_en), 32'(exp_en));
        tick();
        rst_n = 1'b0; enable = 1'b0;
        tick();
        model_reset();
        check("midrst_sched_en", 32'(bus.sched_en), 32'd0);
        check("midrst_xbar_en", 32'(bus.xbar_en), 32'd0);
        check("midrst_xbar_sel", 32'(bus.xbar_sel), 32'd0);
        check("midrst_is_busy", 32'(bus.is_busy), 32'd0);
        check("midrst_vnum", 32'(bus.busy_voq_num), 32'd0);
        check("midrst_slot_cnt", 32'(slot_cnt), 32'(m_cnt));
        check("midrst_err_to", 32'(err_timeout), 32'(m_err_to));
        check("midrst_err_cf", 32'(err_conflict), 32'(m_err_cf));
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(bus.sched_en), 32'd0);
        check("post_rst_xbar", 32'(bus.xbar_en), 32'd0);
        $display("reset: mid-slot reset applied, controller idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/xbar_ctrl.md
XBAR_CTRL -- requirements
Module: xbar_ctrl

Interface
REQ-001 Parameter N_PORTS, default 4, number of ingress and egress ports; only 4 is supported.
REQ-002 Parameter WAIT_TIMEOUT, default 15, the maximum number of WAIT cycles to hold for sched_sel_en.
REQ-003 Ports: clk  in  1  single clock; all logic is rising-edge.
REQ-004 Ports: rst_n  in  1  synchronous, active-low reset.
REQ-005 Ports: enable  in  1  software run control.
REQ-006 Ports: slot_len  in  8  transfer-slot length in cycles; 0 is treated as 1.
REQ-007 Ports: voq_empty  in  16  VOQ empty flags; bit 4*i+e = ingress i, VOQ for egress e.
REQ-008 Ports: pkt_last  in  4  per-ingress pulse: the packet ends within the current slot.
REQ-009 Ports: sched_sel_en  in  1  scheduler decision valid.
REQ-010 Ports: sched_sel  in  8  egress per ingress; bits [2i+1:2i] = ingress i.
REQ-011 Ports: sched_en  out  1  one-cycle request to the scheduler.
REQ-012 Ports: is_busy  out  4  ingress is mid-packet.
REQ-013 Ports: busy_voq_num  out  8  egress held by each busy ingress.
REQ-014 Ports: xbar_en  out  4  ingress i drives the crossbar this cycle.
REQ-015 Ports: xbar_sel  out  8  egress for each ingress; valid where xbar_en is set.
REQ-016 Ports: slot_cnt  out  16  completed XFER slots; wraps at 65535 -> 0.
REQ-017 Ports: err_timeout  out  1  sticky flag: the scheduler failed to answer in time.
REQ-018 Ports: err_conflict  out  1  sticky flag: the scheduler granted one egress to two ingresses.

Function
REQ-019 State machine: IDLE -> REQ -> WAIT -> XFER -> (REQ or IDLE).
REQ-020 IDLE: move to REQ on the first cycle enable=1.
REQ-021 REQ: lasts one cycle with sched_en=1; sched_en is 0 in every other state.
REQ-022 is_busy and busy_voq_num change only in the last XFER cycle; they are stable through REQ and WAIT.
REQ-023 WAIT: on sched_sel_en=1, latch sched_sel, compute the grant and move to XFER on the next cycle.
REQ-024 WAIT timeout: after WAIT_TIMEOUT cycles without sched_sel_en, set err_timeout and return to REQ; no XFER occurs and busy state is unchanged.
REQ-025 A sched_sel_en arriving outside WAIT is ignored.
REQ-026 Candidate rule: ingress i is a candidate if is_busy[i]=1, or if voq_empty[4i+sel_i]=0.
REQ-027 Busy override: for a busy ingress, xbar_sel_i is forced to busy_voq_num_i regardless of sched_sel.
REQ-028 Conflict resolution: when two or more candidates target one egress, priority goes to a busy ingress first, then to the lowest index.
REQ-029 Conflict losers get xbar_en=0, and err_conflict is set.
REQ-030 XFER: xbar_en/xbar_sel are held constant for exactly max(slot_len,1) cycles, starting the cycle after sched_sel_en.
REQ-031 xbar_en=0 outside XFER.
REQ-032 pkt_last is OR-accumulated per ingress across XFER cycles.
REQ-033 In the last XFER cycle, each enabled ingress becomes busy=0 if its accumulated pkt_last is set.
REQ-034 In the last XFER cycle, each enabled ingress otherwise becomes busy=1 with busy_voq_num=xbar_sel.
REQ-035 Ingresses that were not enabled keep their busy state; the accumulator then clears.
REQ-036 slot_cnt increments once per completed XFER.
REQ-037 End of XFER: go to REQ if enable=1, else IDLE; enable is sampled only in IDLE and the last XFER cycle.
REQ-038 The slot_len value is captured on entry to XFER; changes during XFER take effect next slot.
REQ-039 Error flags clear only on reset.

Reset
REQ-040 With rst_n=0 at a clock edge: state=IDLE; sched_en, is_busy, busy_voq_num, xbar_en, xbar_sel, slot_cnt, err_timeout, err_conflict, counters and accumulators are all 0.
REQ-041 Reset mid-XFER or mid-WAIT aborts immediately; the next cycle after rst_n=1 is IDLE.

Structure
REQ-042 Shared package sched_pkg holds N_PORTS, PORT_W=2, WAIT_TIMEOUT, and the state enum {IDLE, REQ, WAIT, XFER}; sched reuses it.
REQ-043 One combinational sub-module, xbar_grant (candidates, busy mask, selections -> xbar_en, conflict), is instantiated once.

Verification
REQ-044 Basic slot: enable=1, slot_len=4, all VOQs non-empty, sched_sel=0xE4 answered 2 cycles after sched_en, pkt_last=0xF -> xbar_en=0xF, xbar_sel=0xE4 for 4 cycles, is_busy=0 after, slot_cnt=1.
REQ-045 Multi-slot packet: ingress 1 active to egress 2 with pkt_last[1]=0 -> is_busy=0x2, busy_voq_num[3:2]=2; next slot with sched_sel[3:2]=0 -> xbar_sel[3:2]=2.
REQ-046 Conflict: sched_sel=0x00, all non-empty, nothing busy -> xbar_en=0x1, err_conflict=1.
REQ-047 Timeout: no sched_sel_en for 15 WAIT cycles -> err_timeout=1, new sched_en pulse, no xbar_en, slot_cnt unchanged.
REQ-048 Boundaries: slot_len=0 gives a 1-cycle XFER; slot_cnt preset near 65535 wraps to 0; enable dropped mid-XFER completes the slot then goes IDLE.
REQ-049 Reset: rst_n=0 asserted mid-XFER -> all outputs 0 the next cycle, and the FSM is IDLE.
